// File: rtl/relu_pkg.sv
// Shared types and helpers for the ReLU backprop unit.
// The mask is the sign-and-nonzero test of a pre-activation value.
package relu_pkg;

  localparam int PRECISION_DEFAULT = 16;
  localparam int PRECISION_W = PRECISION_DEFAULT;

  typedef logic signed [PRECISION_W-1:0] data_t;

  function automatic bit relu_mask(data_t x);
    return !x[PRECISION_W-1] && (|x);
  endfunction

endpackage

// File: rtl/relu_backprop_unit_fifo.sv
// One-bit-wide mask FIFO with count, clear and full/empty.
// Pushes and pops are internally gated by the registered count.
module relu_mask_fifo
  import relu_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          wdata_i,
  input  logic          pop_i,
  output logic          rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/relu_backprop_unit.sv
// ReLU forward stage that records masks and gates backward gradients.
// Results are registered; output paths carry no backpressure.
module relu_backprop_unit
  import relu_pkg::*;
#(
  parameter int PRECISION = PRECISION_DEFAULT,
  parameter int DEPTH = 64,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_i,
  input  logic                        fwd_valid_i,
  output logic                        fwd_ready_o,
  input  logic signed [PRECISION-1:0] fwd_data_i,
  output logic                        fwd_out_valid_o,
  output logic signed [PRECISION-1:0] fwd_out_data_o,
  input  logic                        bwd_valid_i,
  output logic                        bwd_ready_o,
  input  logic signed [PRECISION-1:0] bwd_grad_i,
  output logic                        bwd_out_valid_o,
  output logic signed [PRECISION-1:0] bwd_out_grad_o,
  output logic [CW-1:0]               count_o,
  output logic                        underflow_o
);

  logic full;
  logic empty;
  logic mask_rd;
  logic fwd_pos;
  logic fwd_acc;
  logic bwd_acc;

  logic                        fvld_q, fvld_d;
  logic signed [PRECISION-1:0] fdat_q, fdat_d;
  logic                        bvld_q, bvld_d;
  logic signed [PRECISION-1:0] bgrd_q, bgrd_d;
  logic                        uf_q, uf_d;

  if (PRECISION == PRECISION_W) begin : g_pkg_mask
    assign fwd_pos = relu_mask(fwd_data_i);
  end else begin : g_gen_mask
    assign fwd_pos = !fwd_data_i[PRECISION-1] && (|fwd_data_i);
  end

  // Ready is held low during reset so every output reads zero.
  assign fwd_ready_o = !full && !rst;
  assign bwd_ready_o = !empty;

  assign fwd_acc = fwd_valid_i && fwd_ready_o && !clear_i;
  assign bwd_acc = bwd_valid_i && bwd_ready_o && !clear_i;

  relu_mask_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .push_i  (fwd_acc),
    .wdata_i (fwd_pos),
    .pop_i   (bwd_acc),
    .rdata_o (mask_rd),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

  always_comb begin
    fvld_d = fwd_acc;
    fdat_d = fdat_q;
    bvld_d = bwd_acc;
    bgrd_d = bgrd_q;
    uf_d   = uf_q;
    if (fwd_acc) fdat_d = fwd_pos ? fwd_data_i : '0;
    if (bwd_acc) bgrd_d = mask_rd ? bwd_grad_i : '0;
    if (clear_i) uf_d = 1'b0;
    else if (bwd_valid_i && empty) uf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fvld_q <= 1'b0;
      fdat_q <= '0;
      bvld_q <= 1'b0;
      bgrd_q <= '0;
      uf_q   <= 1'b0;
    end else begin
      fvld_q <= fvld_d;
      fdat_q <= fdat_d;
      bvld_q <= bvld_d;
      bgrd_q <= bgrd_d;
      uf_q   <= uf_d;
    end
  end

  assign fwd_out_valid_o = fvld_q;
  assign fwd_out_data_o  = fdat_q;
  assign bwd_out_valid_o = bvld_q;
  assign bwd_out_grad_o  = bgrd_q;
  assign underflow_o     = uf_q;

endmodule

// File: tb/tb_relu_backprop_unit.sv
// Randomized self-checking bench for relu_backprop_unit.
// A queue of mask bits models the FIFO and ordering rules.
module tb_relu_backprop_unit;

  localparam int P  = 16;
  localparam int D  = 64;
  localparam int CW = $clog2(D + 1);

  logic                clk = 0;
  logic                rst = 1;
  logic                clear = 0;
  logic                fwd_valid = 0;
  logic                fwd_ready;
  logic signed [P-1:0] fwd_data = '0;
  logic                fwd_out_valid;
  logic signed [P-1:0] fwd_out_data;
  logic                bwd_valid = 0;
  logic                bwd_ready;
  logic signed [P-1:0] bwd_grad = '0;
  logic                bwd_out_valid;
  logic signed [P-1:0] bwd_out_grad;
  logic [CW-1:0]       count;
  logic                underflow;

  int vectors = 0;
  int miscompares = 0;

  bit mq[$];
  logic                e_fv, e_bv, e_uf;
  logic signed [P-1:0] e_fd, e_bg;

  always #5 clk = ~clk;

  relu_backprop_unit #(.PRECISION(P), .DEPTH(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (clear),
    .fwd_valid_i     (fwd_valid),
    .fwd_ready_o     (fwd_ready),
    .fwd_data_i      (fwd_data),
    .fwd_out_valid_o (fwd_out_valid),
    .fwd_out_data_o  (fwd_out_data),
    .bwd_valid_i     (bwd_valid),
    .bwd_ready_o     (bwd_ready),
    .bwd_grad_i      (bwd_grad),
    .bwd_out_valid_o (bwd_out_valid),
    .bwd_out_grad_o  (bwd_out_grad),
    .count_o         (count),
    .underflow_o     (underflow)
  );

  task automatic model_reset();
    mq.delete();
    e_fv = 0; e_bv = 0; e_uf = 0; e_fd = '0; e_bg = '0;
  endtask

  // Applies one cycle of inputs and advances the reference model.
  task automatic drive(input logic fv, input logic signed [P-1:0] fd,
                       input logic bv, input logic signed [P-1:0] bg,
                       input logic clr);
    int sz;
    bit m;
    sz = mq.size();
    fwd_valid = fv; fwd_data = fd;
    bwd_valid = bv; bwd_grad = bg; clear = clr;
    e_fv = 0; e_bv = 0;
    if (clr) begin
      mq.delete();
      e_uf = 0;
    end else begin
      if (bv && sz == 0) e_uf = 1;
      if (bv && sz > 0) begin
        m = mq.pop_front();
        e_bv = 1;
        e_bg = m ? bg : '0;
      end
      if (fv && sz < D) begin
        mq.push_back(fd > 0);
        e_fv = 1;
        e_fd = (fd > 0) ? fd : '0;
      end
    end
    @(posedge clk); #1;
    fwd_valid = 0; bwd_valid = 0; clear = 0;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({fwd_ready, bwd_ready, fwd_out_valid, bwd_out_valid, underflow} !== 5'b0
        || fwd_out_data !== '0 || bwd_out_grad !== '0 || count !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs fr=%b br=%b fv=%b bv=%b uf=%b cnt=%0d want all 0",
               fwd_ready, bwd_ready, fwd_out_valid, bwd_out_valid, underflow, count);
    end
    @(posedge clk); #2; rst = 0;
    @(posedge clk); #1;
    model_reset();
    vectors++;
    if (fwd_ready !== 1'b1 || bwd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready fr=%b br=%b want 1 0", fwd_ready, bwd_ready);
    end
  endtask

  task automatic test_fwd_bwd();
    logic signed [P-1:0] xs[4] = '{16'sd5, -16'sd3, 16'sd0, 16'sd32767};
    logic signed [P-1:0] gs[4] = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    logic signed [P-1:0] fo[4] = '{16'sd5, 16'sd0, 16'sd0, 16'sd32767};
    logic signed [P-1:0] bo[4] = '{16'sd10, 16'sd0, 16'sd0, 16'sd40};
    for (int i = 0; i < 4; i++) begin
      drive(1, xs[i], 0, '0, 0);
      vectors++;
      if (fwd_out_valid !== 1'b1 || fwd_out_data !== fo[i]) begin
        miscompares++;
        $display("FAIL fwd_out[%0d] v=%b d=%0d want 1 %0d", i, fwd_out_valid, fwd_out_data, fo[i]);
      end
    end
    drive(0, '0, 0, '0, 0);
    vectors++;
    if (fwd_out_valid !== 1'b0 || fwd_out_data !== fo[3] || count !== CW'(4)) begin
      miscompares++;
      $display("FAIL fwd_idle v=%b d=%0d cnt=%0d want 0 %0d 4", fwd_out_valid, fwd_out_data, count, fo[3]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, gs[i], 0);
      vectors++;
      if (bwd_out_valid !== 1'b1 || bwd_out_grad !== bo[i] || bwd_out_grad !== e_bg) begin
        miscompares++;
        $display("FAIL bwd_out[%0d] v=%b g=%0d want 1 %0d", i, bwd_out_valid, bwd_out_grad, bo[i]);
      end
    end
    vectors++;
    if (count !== '0 || bwd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_count cnt=%0d br=%b want 0 0", count, bwd_ready);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) drive(1, 16'sd1, 0, '0, 0);
    vectors++;
    if (count !== CW'(D) || fwd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full cnt=%0d fr=%b want %0d 0", count, fwd_ready, D);
    end
    drive(1, 16'sd9, 0, '0, 0);
    vectors++;
    if (fwd_out_valid !== 1'b0 || count !== CW'(D)) begin
      miscompares++;
      $display("FAIL overflow_push v=%b cnt=%0d want 0 %0d", fwd_out_valid, count, D);
    end
    drive(1, 16'sd2, 1, 16'sd55, 0);
    vectors++;
    if (fwd_out_valid !== 1'b0 || bwd_out_valid !== 1'b1 || bwd_out_grad !== 16'sd55
        || count !== CW'(D - 1)) begin
      miscompares++;
      $display("FAIL full_push_pop fv=%b bv=%b g=%0d cnt=%0d want 0 1 55 %0d",
               fwd_out_valid, bwd_out_valid, bwd_out_grad, count, D - 1);
    end
  endtask

  task automatic test_underflow();
    drive(0, '0, 0, '0, 1);
    vectors++;
    if (bwd_ready !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL clear_empty br=%b cnt=%0d want 0 0", bwd_ready, count);
    end
    drive(0, '0, 1, 16'sd7, 0);
    vectors++;
    if (bwd_out_valid !== 1'b0 || underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_set bv=%b uf=%b want 0 1", bwd_out_valid, underflow);
    end
    drive(1, 16'sd4, 0, '0, 0);
    vectors++;
    if (underflow !== 1'b1 || count !== CW'(1)) begin
      miscompares++;
      $display("FAIL underflow_sticky uf=%b cnt=%0d want 1 1", underflow, count);
    end
    drive(0, '0, 0, '0, 1);
    vectors++;
    if (underflow !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL underflow_clear uf=%b cnt=%0d want 0 0", underflow, count);
    end
  endtask

  task automatic test_simultaneous();
    drive(1, 16'sd3, 0, '0, 0);
    drive(1, -16'sd2, 0, '0, 0);
    drive(1, 16'sd9, 0, '0, 0);
    drive(1, -16'sd32768, 0, '0, 0);
    vectors++;
    if (fwd_out_data !== 16'sd0 || count !== CW'(4)) begin
      miscompares++;
      $display("FAIL most_negative d=%0d cnt=%0d want 0 4", fwd_out_data, count);
    end
    drive(1, -16'sd8, 1, -16'sd100, 0);
    vectors++;
    if (bwd_out_valid !== 1'b1 || bwd_out_grad !== -16'sd100 || fwd_out_valid !== 1'b1
        || fwd_out_data !== 16'sd0 || count !== CW'(4)) begin
      miscompares++;
      $display("FAIL simul bv=%b g=%0d fv=%b d=%0d cnt=%0d want 1 -100 1 0 4",
               bwd_out_valid, bwd_out_grad, fwd_out_valid, fwd_out_data, count);
    end
  endtask

  task automatic test_wrap();
    logic signed [P-1:0] x, g;
    int bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      x = P'($urandom);
      g = P'($urandom);
      drive(1, x, 1, g, 0);
      vectors++;
      if (bwd_out_valid !== e_bv || bwd_out_grad !== e_bg || fwd_out_data !== e_fd
          || underflow !== 1'b0 || count !== CW'(mq.size())) begin
        miscompares++;
        $display("FAIL wrap[%0d] bv=%b g=%0d d=%0d uf=%b cnt=%0d want %b %0d %0d 0 %0d",
                 i, bwd_out_valid, bwd_out_grad, fwd_out_data, underflow, count,
                 e_bv, e_bg, e_fd, mq.size());
      end
    end
  endtask

  task automatic test_clear_reset();
    drive(0, '0, 0, '0, 1);
    for (int i = 0; i < 10; i++) drive(1, P'($urandom), 0, '0, 0);
    vectors++;
    if (count !== CW'(10)) begin
      miscompares++;
      $display("FAIL ten_stored cnt=%0d want 10", count);
    end
    drive(1, 16'sd11, 0, '0, 1);
    vectors++;
    if (count !== '0 || fwd_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_with_push cnt=%0d fv=%b want 0 0", count, fwd_out_valid);
    end
    drive(1, 16'sd12, 0, '0, 0);
    drive(1, 16'sd13, 1, 16'sd77, 0);
    #1 rst = 1;
    #1;
    model_reset();
    vectors++;
    if (fwd_out_valid !== 1'b0 || bwd_out_valid !== 1'b0 || fwd_out_data !== '0
        || bwd_out_grad !== '0 || count !== '0 || fwd_ready !== 1'b0 || bwd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset fv=%b bv=%b d=%0d g=%0d cnt=%0d want all 0",
               fwd_out_valid, bwd_out_valid, fwd_out_data, bwd_out_grad, count);
    end
    #1 rst = 0;
    drive(0, '0, 1, 16'sd5, 0);
    vectors++;
    if (bwd_out_valid !== 1'b0 || underflow !== 1'b1 || fwd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset bv=%b uf=%b fr=%b want 0 1 1", bwd_out_valid, underflow, fwd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_bwd();
    test_fill();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_clear_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
